serial_sub_n: RTL and testbench

Parametrised bit-serial subtractor that computes Y = A - B - borw_in over WIDTH clock cycles, LSB first. It uses one full-subtractor cell with a registered borrow, and sequences operands through shift registers. It sits in the arithmetic datapath where multi-bit subtraction is needed but area matters more than latency. A start/busy/done handshake brackets each operation. Two's-complement overflow is also flagged.

---
 rtl/serial_sub_n.sv | 146 ++++++++++++++
 tb/tb_serial_sub_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_n.sv
// Bit-serial subtractor: Y = A - B - borw_in, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow walks the operand shift registers.
module serial_sub_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borw_in,
    output logic [WIDTH-1:0] Y,
    output logic             borw_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             borw_q, borw_d;
    logic             ovf_q, ovf_d;

    logic             bit_a, bit_b, diff, br_nxt, last;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor cell
    assign bit_a  = a_sr_q[0];
    assign bit_b  = b_sr_q[0];
    assign diff   = bit_a ^ bit_b ^ br_q;
    assign br_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    // Result enters at the MSB so the final word is aligned after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = diff;
        end else begin : g_res_wn
            assign res_shift = {diff, res_sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        y_d      = y_q;
        borw_d   = borw_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = A;
                    b_sr_d   = B;
                    br_d     = borw_in;
                    cnt_d    = '0;
                    res_sr_d = '0;
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift;
                br_d     = br_nxt;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    y_d    = res_shift;
                    borw_d = br_nxt;
                    // diff of the last step is the result sign bit
                    ovf_d  = (a_msb_q ^ b_msb_q) & (diff ^ a_msb_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            y_q      <= '0;
            borw_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            y_q      <= y_d;
            borw_q   <= borw_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Y        = y_q;
    assign borw_out = borw_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_serial_sub_n.sv
// Directed bench for serial_sub_n at WIDTH=8 and WIDTH=1.
module tb_serial_sub_n;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] A, B;
    logic       borw_in;
    logic [7:0] Y;
    logic       borw_out, ovf, busy, done;

    logic       start1, a1, b1, bi1;
    logic [0:0] y1;
    logic       bo1, ovf1, busy1, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_sub_n #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .borw_in(borw_in),
        .Y(Y), .borw_out(borw_out), .ovf(ovf), .busy(busy), .done(done)
    );

    serial_sub_n #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .borw_in(bi1),
        .Y(y1), .borw_out(bo1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation on the 8-bit DUT and reports latency, busy span and results.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output logic [7:0] y, output logic bo, output logic ov,
                          output int lat, output int bcnt);
        A = a; B = b; borw_in = bi; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
        y = Y; bo = borw_out; ov = ovf;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; borw_in = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        tick(); tick();
        checks++;
        if ({Y, borw_out, ovf, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got Y=%h bo=%b ovf=%b busy=%b done=%b, want all 0",
                     Y, borw_out, ovf, busy, done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] y; logic bo, ov; int lat, bcnt;
        run_op(8'h05, 8'h03, 1'b0, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_05_03: got Y=%h bo=%b ovf=%b, want Y=02 bo=0 ovf=0", y, bo, ov);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges after accept, want 8", lat);
        end
        checks++;
        if (bcnt !== 9) begin
            errors++;
            $display("FAIL basic_busy_span: got %0d cycles, want 9", bcnt);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] y; logic bo, ov; int lat, bcnt;
        run_op(8'h00, 8'h01, 1'b0, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_00_01: got Y=%h bo=%b ovf=%b, want Y=ff bo=1 ovf=0", y, bo, ov);
        end
        run_op(8'hFF, 8'hFF, 1'b1, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_ff_ff_1: got Y=%h bo=%b ovf=%b, want Y=ff bo=1 ovf=0", y, bo, ov);
        end
        run_op(8'hA5, 8'h5A, 1'b1, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'h4A, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL borrow_a5_5a_1: got Y=%h bo=%b ovf=%b, want Y=4a bo=0 ovf=1", y, bo, ov);
        end
        checks++;
        if (Y !== 8'h4A) begin
            errors++;
            $display("FAIL result_hold: got Y=%h in idle, want 4a", Y);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] y; logic bo, ov; int lat, bcnt;
        run_op(8'h80, 8'h01, 1'b0, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'h7F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_80_01: got Y=%h bo=%b ovf=%b, want Y=7f bo=0 ovf=1", y, bo, ov);
        end
        run_op(8'h7F, 8'hFF, 1'b0, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'h80, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_7f_ff: got Y=%h bo=%b ovf=%b, want Y=80 bo=1 ovf=1", y, bo, ov);
        end
    endtask

    task automatic test_back_to_back();
        int t, t1, t2;
        logic idle_seen;
        logic [7:0] y_first, y_second;
        A = 8'h10; B = 8'h03; borw_in = 1'b0; start = 1'b1;
        tick();
        t = 0; t1 = -1; t2 = -1; idle_seen = 1'b0;
        y_first = '0; y_second = '0;
        while (t2 < 0 && t < 40) begin
            if (t == 3) begin A = 8'hAA; B = 8'h11; end
            tick();
            t++;
            if (t1 >= 0 && !busy) idle_seen = 1'b1;
            if (done && t1 < 0) begin t1 = t; y_first = Y; end
            else if (done && t1 >= 0) begin t2 = t; y_second = Y; end
        end
        start = 1'b0;
        checks++;
        if (y_first !== 8'h0D || t1 !== 8) begin
            errors++;
            $display("FAIL b2b_first: got Y=%h at edge %0d, want Y=0d at edge 8", y_first, t1);
        end
        checks++;
        if (t2 - t1 !== 10) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles between done pulses, want 10", t2 - t1);
        end
        checks++;
        if (y_second !== 8'h99 || !idle_seen) begin
            errors++;
            $display("FAIL b2b_second: got Y=%h idle_seen=%b, want Y=99 idle_seen=1", y_second, idle_seen);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] y; logic bo, ov; int lat, bcnt;
        logic done_seen;
        A = 8'h55; B = 8'h22; borw_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({Y, borw_out, ovf, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL abort_reset: got Y=%h bo=%b ovf=%b busy=%b done=%b, want all 0",
                     Y, borw_out, ovf, busy, done);
        end
        tick(); tick();
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            tick();
            if (done || busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got activity=%b after abort, want 0", done_seen);
        end
        run_op(8'h55, 8'h22, 1'b0, y, bo, ov, lat, bcnt);
        checks++;
        if ({y, bo, ov} !== {8'h33, 1'b0, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL abort_restart: got Y=%h bo=%b ovf=%b lat=%0d, want Y=33 bo=0 ovf=0 lat=8",
                     y, bo, ov, lat);
        end
    endtask

    task automatic test_width1();
        // {Y, borw_out} indexed by {A, B, borw_in}
        logic [1:0] exp_tbl [8];
        logic [2:0] v;
        int lat;
        exp_tbl = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; bi1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 10) begin
                tick();
                lat++;
            end
            checks++;
            if ({y1, bo1} !== exp_tbl[i] || lat !== 1) begin
                errors++;
                $display("FAIL w1_vec_%0d%0d%0d: got Y=%b bo=%b lat=%0d, want Y=%b bo=%b lat=1",
                         v[2], v[1], v[0], y1, bo1, lat, exp_tbl[i][1], exp_tbl[i][0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
